ks_loop_filter: RTL
===================

Name: ks_loop_filter

Overview:
- Karplus-Strong feedback filter that sits directly downstream of the pluck delay line.
- Consumes the delay-line output sample stream and applies a two-tap average (lowpass) or a passthrough, then a decay gain.
- Returns the result as the feedback sample the delay line writes back after the noise burst ends.
- Fixed 3-cycle pipeline, qualified by a sample enable, with a flush for a new pluck.

Parameters:
- DATA_W, 32, signed sample width of input and output.
- GAIN_W, 17, unsigned decay gain width, Q1.16 format (0x10000 = 1.0).

Ports:
- clk  in  1  system clock, all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- en  in  1  sample enable; din is consumed on cycles where en=1.
- flush  in  1  one-cycle pulse at pluck start; clears history and pipeline.
- mode  in  1  0 = two-tap average, 1 = passthrough (bright, no averaging).
- decay  in  GAIN_W  gain in Q1.16; values above 0x10000 are clamped to 0x10000.
- din  in  DATA_W  signed sample from the delay-line output q.
- dout  out  DATA_W  signed filtered feedback sample (dfilter of the delay line).
- dout_valid  out  1  one-cycle strobe, high when dout is updated.

Behaviour:
- Reset: synchronous, active-high. dout=0, dout_valid=0, history x_prev=0, all stage valids=0, all pipeline data registers=0.
- Stage 1 (en=1 & !flush):
  - s1_sum = sign-extended din + x_prev (DATA_W+1 bits), or 2*din when mode=1.
  - x_prev <= din; v1 <= 1. Otherwise v1 <= 0.
- Stage 2:
  - avg = s1_sum >>> 1 (arithmetic shift, floor), exactly DATA_W bits.
  - g = min(decay, 0x10000).
  - prod = avg * signed'({1'b0,g}), DATA_W+GAIN_W+1 bits. v2 <= v1.
- Stage 3:
  - r = (prod + 0x8000) >>> 16 (round half up).
  - Saturate r to the signed DATA_W range. Saturation never triggers for legal math; the bench asserts it never fires.
  - When v2=1: dout <= r, dout_valid <= 1. Otherwise dout holds its value, dout_valid <= 0.
- Latency: din accepted on cycle N → dout_valid high on cycle N+3. Throughput is 1 sample/clk with en tied high.
- dout holds its last value between strobes, so the delay line may sample it on any cycle.
- Flush:
  - Same cycle: x_prev <= 0, v1/v2 <= 0, din that cycle is dropped. dout is NOT cleared.
  - Flush wins over a simultaneous en.
  - The first sample after flush averages against 0.
- Reset mid-stream: all in-flight samples are discarded; no dout_valid until 3 cycles after the next accepted en.
- mode and decay are sampled in stage 1 and stage 2 respectively, without staging. Changing either mid-stream takes effect on the next sample through that stage; no glitch protection is required.
- Boundaries:
  - decay=0 → dout=0 for every valid.
  - decay=0x10000, mode=1 → dout=din exactly.
  - din=x_prev=-2^31 → avg=-2^31, no overflow.
  - +2^31-1 twice at gain 1.0 → +2^31-1.

Decomposition:
- Package ks_pkg:
  - SAMPLE_W=32, GAIN_W=17, GAIN_ONE=17'h10000, ROUND_HALF=16'h8000.
  - typedef sample_t (signed [31:0]), typedef gain_t ([16:0]).
  - Shared by the delay line, noise source, and this filter.
- One natural sub-module: ks_round_sat (the stage-3 round-and-saturate, parameterised on input/output widths). It is reusable by a future pitch-fraction allpass.
- The rest stays inline.

Test Plan:
- Reset with clk running → dout=0, dout_valid=0 for all cycles; after release, en=1, din=100, mode=1, decay=0x10000 → dout=100 with dout_valid 3 cycles later.
- Impulse, mode=0, decay=0x8000, en=1 continuously: din=1000,0,0 → dout=250,250,0 on consecutive valid cycles, starting 3 cycles after the first sample.
- Rounding: mode=1, decay=0x8000, din=3 → dout=2 (1.5 rounds up); din=-3 → dout=-1 (-1.5 rounds up toward +inf).
- Clamp and extremes: decay=0x1FFFF, mode=0, din=2^31-1 twice → dout=2^31-1; din=-2^31 twice → -2^31; saturation assertion never fires.
- Flush: stream 500,500, then flush with en=1 and din=900 in the same cycle, then din=400 → 900 is dropped. The output for 400 is 200 (averaged with 0, decay 1.0). dout holds 500 through the gap and dout_valid is low for the dropped slot.
- Gated enable: en toggled 1,0,1,0 with din 10,x,30,x, mode=0, decay=0x10000 → dout_valid pulses exactly twice with dout=5 then 20. Data on en=0 cycles is ignored and history is not updated.

Source files
------------

// File: rtl/ks_pkg.sv
// Shared Karplus-Strong definitions: sample/gain widths, the Q1.16 unity gain
// and the rounding constant. Used by the delay line, the noise source and the
// loop filter.
package ks_pkg;

  localparam int unsigned SAMPLE_W    = 32;
  localparam int unsigned GAIN_W      = 17;
  localparam int unsigned GAIN_FRAC_W = 16;

  localparam logic [16:0] GAIN_ONE   = 17'h10000;
  localparam logic [15:0] ROUND_HALF = 16'h8000;

  typedef logic signed [SAMPLE_W-1:0] sample_t;
  typedef logic        [GAIN_W-1:0]   gain_t;

endpackage

// File: rtl/ks_loop_filter_if.sv
// Sample-stream bundle between the delay line (master) and the loop filter
// (slave).
//   en         sample enable, din consumed when high
//   flush      one-cycle pluck-start pulse, clears history and pipeline
//   mode       0 = two-tap average, 1 = passthrough
//   decay      Q1.16 decay gain, clamped to 1.0 by the filter
//   din        signed sample from the delay line
//   dout       signed feedback sample, holds between strobes
//   dout_valid one-cycle strobe when dout updates
interface ks_loop_filter_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned GAIN_W = 17
) ();

  logic                     en;
  logic                     flush;
  logic                     mode;
  logic        [GAIN_W-1:0] decay;
  logic signed [DATA_W-1:0] din;
  logic signed [DATA_W-1:0] dout;
  logic                     dout_valid;

  modport master (
    output en, flush, mode, decay, din,
    input  dout, dout_valid
  );

  modport slave (
    input  en, flush, mode, decay, din,
    output dout, dout_valid
  );

endinterface

// File: rtl/ks_round_sat.sv
// Round-half-up right shift followed by saturation to a narrower signed width.
//   din  signed fixed-point value, SHIFT fractional bits
//   dout rounded, saturated integer result
//   sat  high when din did not fit and dout was clamped
module ks_round_sat
  import ks_pkg::*;
#(
  parameter int unsigned IN_W  = 50,
  parameter int unsigned OUT_W = 32,
  parameter int unsigned SHIFT = GAIN_FRAC_W
) (
  input  logic signed [IN_W-1:0]  din,
  output logic signed [OUT_W-1:0] dout,
  output logic                    sat
);

  // One guard bit so adding the half-LSB can never wrap.
  localparam int unsigned BW = IN_W + 1;
  localparam logic signed [BW-1:0] Half = {{(BW - SHIFT){1'b0}}, 1'b1, {(SHIFT - 1){1'b0}}};

  logic signed [BW-1:0] biased;
  logic signed [BW-1:0] shifted;
  logic                 upper_ones;
  logic                 upper_zeros;

  always_comb begin
    biased      = {din[IN_W-1], din} + Half;
    shifted     = biased >>> SHIFT;
    // Result fits when every bit from the output sign bit upward agrees.
    upper_ones  = &shifted[BW-1:OUT_W-1];
    upper_zeros = ~|shifted[BW-1:OUT_W-1];
    sat         = ~(upper_ones | upper_zeros);
    if (!sat) begin
      dout = shifted[OUT_W-1:0];
    end else if (shifted[BW-1]) begin
      dout = {1'b1, {(OUT_W - 1){1'b0}}};
    end else begin
      dout = {1'b0, {(OUT_W - 1){1'b1}}};
    end
  end

endmodule

// File: rtl/ks_loop_filter.sv
// Karplus-Strong loop filter: two-tap average (or passthrough) followed by a
// Q1.16 decay gain, producing the feedback sample written back into the delay
// line. Fixed 3-cycle pipeline qualified by en, cleared by flush.
//   clk   rising-edge clock
//   reset synchronous active-high reset
//   bus   sample stream (slave side): en/flush/mode/decay/din in,
//         dout/dout_valid out
module ks_loop_filter #(
  parameter int unsigned DATA_W = ks_pkg::SAMPLE_W,
  parameter int unsigned GAIN_W = ks_pkg::GAIN_W
) (
  input logic             clk,
  input logic             reset,
  ks_loop_filter_if.slave bus
);

  import ks_pkg::*;

  localparam int unsigned SumW  = DATA_W + 1;
  localparam int unsigned ProdW = DATA_W + GAIN_W + 1;
  localparam logic [GAIN_W-1:0] GainMax = GAIN_W'(GAIN_ONE);

  logic                     accept;
  logic signed [DATA_W-1:0] x_prev_q;
  logic signed [SumW-1:0]   s1_sum_d;
  logic signed [SumW-1:0]   s1_sum_q;
  logic                     v1_q;
  logic signed [SumW-1:0]   avg_w;
  logic        [GAIN_W-1:0] gain;
  logic signed [ProdW-1:0]  avg_ext;
  logic signed [ProdW-1:0]  gain_ext;
  logic signed [ProdW-1:0]  prod_d;
  logic signed [ProdW-1:0]  prod_q;
  logic                     v2_q;
  logic signed [DATA_W-1:0] r;
  logic                     sat;
  logic                     sat_hit;
  logic signed [DATA_W-1:0] dout_q;
  logic                     dout_valid_q;

  always_comb begin
    // Flush takes priority over a simultaneous enable; that sample is dropped.
    accept = bus.en & ~bus.flush;

    // Stage 1: passthrough doubles din so the common >>>1 restores it.
    if (bus.mode) begin
      s1_sum_d = {bus.din, 1'b0};
    end else begin
      s1_sum_d = {bus.din[DATA_W-1], bus.din} + {x_prev_q[DATA_W-1], x_prev_q};
    end

    // Stage 2: floor-halve, clamp gain to 1.0, signed multiply.
    // The halved sum always fits DATA_W bits; keeping the extra sign bit is harmless.
    avg_w    = s1_sum_q >>> 1;
    gain     = (bus.decay > GainMax) ? GainMax : bus.decay;
    avg_ext  = {{(ProdW - SumW){avg_w[SumW-1]}}, avg_w};
    gain_ext = {{(ProdW - GAIN_W){1'b0}}, gain};
    prod_d   = avg_ext * gain_ext;
  end

  ks_round_sat #(
    .IN_W (ProdW),
    .OUT_W(DATA_W),
    .SHIFT(GAIN_FRAC_W)
  ) u_round_sat (
    .din (prod_q),
    .dout(r),
    .sat (sat)
  );

  // Only meaningful for a live sample; legal inputs never saturate.
  assign sat_hit = sat & v2_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      x_prev_q     <= '0;
      s1_sum_q     <= '0;
      v1_q         <= 1'b0;
      prod_q       <= '0;
      v2_q         <= 1'b0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
    end else begin
      v1_q         <= accept;
      v2_q         <= v1_q & ~bus.flush;
      dout_valid_q <= v2_q;

      if (bus.flush) begin
        x_prev_q <= '0;
      end else if (accept) begin
        x_prev_q <= bus.din;
      end

      if (accept) begin
        s1_sum_q <= s1_sum_d;
      end
      if (v1_q) begin
        prod_q <= prod_d;
      end
      // dout is deliberately left alone by flush so the delay line keeps a value.
      if (v2_q) begin
        dout_q <= r;
      end
    end
  end

  assign bus.dout       = dout_q;
  assign bus.dout_valid = dout_valid_q;

endmodule
